// File: rtl/acc_sequencer.sv
// acc_sequencer: accumulator, operand register and operation sequencer in
// front of the ALU. Each operation steps through EXEC and WB_LO; with
// ACC_HIGH_WB_EN defined, an MPY adds a WB_HI cycle that captures the ALU's
// MR word into ACCH. With the macro undefined there is no WB_HI state,
// o_c10 is tied low and ACCH is constant zero.
module acc_sequencer (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_mbr,
  input  logic        i_acc_wr,
  input  logic [15:0] i_acc_wdata,
  input  logic [15:0] i_br,
  input  logic [15:0] i_mr,
  output logic        o_ready,
  output logic        o_done,
  output logic [15:0] o_acc_alu_p,
  output logic [15:0] o_acc_alu_q,
  output logic [2:0]  o_alu_op,
  output logic        o_alu_en,
  output logic        o_c9,
  output logic        o_c10,
  output logic [15:0] o_acc,
  output logic [15:0] o_acch
);

  localparam logic [2:0] OP_MPY = 3'b010;

`ifdef ACC_HIGH_WB_EN
  typedef enum logic [1:0] {IDLE, EXEC, WB_LO, WB_HI} state_t;
`else
  typedef enum logic [1:0] {IDLE, EXEC, WB_LO} state_t;
`endif

  state_t      state_reg, state_next;
  logic [15:0] acc_reg, acc_next;
  logic [15:0] q_reg, q_next;
  logic [2:0]  op_reg, op_next;
`ifdef ACC_HIGH_WB_EN
  logic [15:0] acch_reg, acch_next;
`endif

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      q_reg     <= '0;
      op_reg    <= '0;
`ifdef ACC_HIGH_WB_EN
      acch_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      q_reg     <= q_next;
      op_reg    <= op_next;
`ifdef ACC_HIGH_WB_EN
      acch_reg  <= acch_next;
`endif
    end
  end

  // Next-state and register updates; start has priority over a direct ACC load.
  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    q_next     = q_reg;
    op_next    = op_reg;
`ifdef ACC_HIGH_WB_EN
    acch_next  = acch_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          op_next    = i_op;
          q_next     = i_mbr;
          state_next = EXEC;
        end else if (i_acc_wr) begin
          acc_next = i_acc_wdata;
        end
      end
      EXEC: begin
        state_next = WB_LO;
      end
      WB_LO: begin
        acc_next = i_br;
`ifdef ACC_HIGH_WB_EN
        if (op_reg == OP_MPY) begin
          state_next = WB_HI;
        end else begin
          acch_next  = '0;
          state_next = IDLE;
        end
`else
        state_next = IDLE;
`endif
      end
`ifdef ACC_HIGH_WB_EN
      WB_HI: begin
        acch_next  = i_mr;
        state_next = IDLE;
      end
`endif
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Strobes and status decoded purely from registered state and OP.
  always_comb begin
    o_ready  = (state_reg == IDLE);
    o_alu_en = (state_reg == EXEC);
    o_c9     = (state_reg == WB_LO);
`ifdef ACC_HIGH_WB_EN
    o_c10    = (state_reg == WB_HI);
    o_done   = ((state_reg == WB_LO) && (op_reg != OP_MPY)) || (state_reg == WB_HI);
    o_acch   = acch_reg;
`else
    o_c10    = 1'b0;
    o_done   = (state_reg == WB_LO);
    o_acch   = '0;
`endif
    o_alu_op    = (state_reg == IDLE) ? 3'b000 : op_reg;
    o_acc       = acc_reg;
    o_acc_alu_p = acc_reg;
    o_acc_alu_q = q_reg;
  end

endmodule

// File: tb/tb_acc_sequencer.sv
// Directed testbench for acc_sequencer. The bench plays the ALU by driving
// i_br / i_mr with the hand-computed result only in the cycle the sequencer
// should capture it, and junk otherwise. Expectations follow ACC_HIGH_WB_EN.
module tb_acc_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [2:0]  i_op;
  logic [15:0] i_mbr;
  logic        i_acc_wr;
  logic [15:0] i_acc_wdata;
  logic [15:0] i_br;
  logic [15:0] i_mr;
  logic        o_ready;
  logic        o_done;
  logic [15:0] o_acc_alu_p;
  logic [15:0] o_acc_alu_q;
  logic [2:0]  o_alu_op;
  logic        o_alu_en;
  logic        o_c9;
  logic        o_c10;
  logic [15:0] o_acc;
  logic [15:0] o_acch;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MPY = 3'b010;
  localparam logic [2:0] OP_AND = 3'b100;

  acc_sequencer dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_op        (i_op),
    .i_mbr       (i_mbr),
    .i_acc_wr    (i_acc_wr),
    .i_acc_wdata (i_acc_wdata),
    .i_br        (i_br),
    .i_mr        (i_mr),
    .o_ready     (o_ready),
    .o_done      (o_done),
    .o_acc_alu_p (o_acc_alu_p),
    .o_acc_alu_q (o_acc_alu_q),
    .o_alu_op    (o_alu_op),
    .o_alu_en    (o_alu_en),
    .o_c9        (o_c9),
    .o_c10       (o_c10),
    .o_acc       (o_acc),
    .o_acch      (o_acch)
  );

  always #5 i_clk = ~i_clk;

  // Advance one cycle; inputs changed after this are sampled at the next edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic load_acc(input logic [15:0] v);
    i_acc_wr = 1'b1;
    i_acc_wdata = v;
    tick();
    i_acc_wr = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    i_start = 1'b0; i_op = '0; i_mbr = '0;
    i_acc_wr = 1'b0; i_acc_wdata = '0;
    i_br = 16'hDEAD; i_mr = 16'hBEEF;
    tick();
    checks++;
    if ({o_ready, o_done, o_alu_en, o_c9, o_c10} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctrl got %b exp %b", {o_ready, o_done, o_alu_en, o_c9, o_c10}, 5'b10000);
    end
    checks++;
    if ({o_acc, o_acch, o_acc_alu_p, o_acc_alu_q, o_alu_op} !== 67'd0) begin
      errors++; $display("FAIL reset_data got acc=%h acch=%h p=%h q=%h op=%b exp all 0", o_acc, o_acch, o_acc_alu_p, o_acc_alu_q, o_alu_op);
    end
    i_rst_n = 1'b1;
    tick();
    $display("reset released ready=%b acc=%h", o_ready, o_acc);
  endtask

  task automatic test_add();
    load_acc(16'h0003);
    checks++;
    if (o_acc !== 16'h0003) begin errors++; $display("FAIL add_load got %h exp %h", o_acc, 16'h0003); end
    i_start = 1'b1; i_op = OP_ADD; i_mbr = 16'h0004;
    tick();                                   // T+1 EXEC
    i_start = 1'b0; i_mbr = 16'hAAAA;
    checks++;
    if ({o_alu_en, o_c9, o_c10, o_done, o_ready} !== 5'b10000) begin
      errors++; $display("FAIL add_exec_ctrl got %b exp %b", {o_alu_en, o_c9, o_c10, o_done, o_ready}, 5'b10000);
    end
    checks++;
    if (o_acc_alu_p !== 16'h0003 || o_acc_alu_q !== 16'h0004) begin
      errors++; $display("FAIL add_exec_operands got p=%h q=%h exp p=0003 q=0004", o_acc_alu_p, o_acc_alu_q);
    end
    tick();                                   // T+2 WB_LO
    i_br = 16'h0007;
    checks++;
    if ({o_alu_en, o_c9, o_c10, o_done, o_ready} !== 5'b01010) begin
      errors++; $display("FAIL add_wb_ctrl got %b exp %b", {o_alu_en, o_c9, o_c10, o_done, o_ready}, 5'b01010);
    end
    tick();                                   // T+3 IDLE
    i_br = 16'hDEAD;
    checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0 || o_acc !== 16'h0007 || o_acch !== 16'h0000 || o_alu_op !== 3'b000) begin
      errors++; $display("FAIL add_result got ready=%b done=%b acc=%h acch=%h op=%b exp ready=1 done=0 acc=0007 acch=0000 op=000", o_ready, o_done, o_acc, o_acch, o_alu_op);
    end
    $display("ADD 0003+0004 -> acc=%h", o_acc);
  endtask

  task automatic test_mpy();
    load_acc(16'h0100);
    i_start = 1'b1; i_op = OP_MPY; i_mbr = 16'h0100;
    tick();                                   // T+1 EXEC
    i_start = 1'b0;
    checks++;
    if (o_alu_en !== 1'b1 || o_alu_op !== OP_MPY) begin
      errors++; $display("FAIL mpy_exec got en=%b op=%b exp en=1 op=010", o_alu_en, o_alu_op);
    end
    tick();                                   // T+2 WB_LO
    i_br = 16'h0000;
`ifdef ACC_HIGH_WB_EN
    i_mr = 16'hBEEF;
    checks++;
    if ({o_c9, o_c10, o_done} !== 3'b100) begin
      errors++; $display("FAIL mpy_wblo got c9c10done=%b exp %b", {o_c9, o_c10, o_done}, 3'b100);
    end
    tick();                                   // T+3 WB_HI
    i_br = 16'hDEAD; i_mr = 16'h0001;
    checks++;
    if ({o_c9, o_c10, o_done, o_ready} !== 4'b0110 || o_alu_op !== OP_MPY) begin
      errors++; $display("FAIL mpy_wbhi got c9c10doneready=%b op=%b exp 0110 op=010", {o_c9, o_c10, o_done, o_ready}, o_alu_op);
    end
    tick();                                   // T+4 IDLE
    i_mr = 16'hBEEF;
    checks++;
    if (o_ready !== 1'b1 || o_done !== 1'b0 || o_acc !== 16'h0000 || o_acch !== 16'h0001) begin
      errors++; $display("FAIL mpy_result got ready=%b done=%b acc=%h acch=%h exp 1 0 0000 0001", o_ready, o_done, o_acc, o_acch);
    end
`else
    i_mr = 16'h0001;
    checks++;
    if ({o_c9, o_c10, o_done} !== 3'b101) begin
      errors++; $display("FAIL mpy_wblo got c9c10done=%b exp %b", {o_c9, o_c10, o_done}, 3'b101);
    end
    tick();                                   // T+3 IDLE
    i_br = 16'hDEAD;
    checks++;
    if (o_ready !== 1'b1 || o_c10 !== 1'b0 || o_acc !== 16'h0000 || o_acch !== 16'h0000) begin
      errors++; $display("FAIL mpy_result got ready=%b c10=%b acc=%h acch=%h exp 1 0 0000 0000", o_ready, o_c10, o_acc, o_acch);
    end
    i_mr = 16'hBEEF;
`endif
    $display("MPY 0100*0100 -> acch=%h acc=%h", o_acch, o_acc);
  endtask

  // Starts in the first IDLE cycle after the MPY; ACC is 0 here.
  task automatic test_back_to_back();
    i_start = 1'b1; i_op = OP_ADD; i_mbr = 16'h0002;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_alu_en !== 1'b1 || o_acc_alu_q !== 16'h0002) begin
      errors++; $display("FAIL b2b_first_accept got en=%b q=%h exp en=1 q=0002", o_alu_en, o_acc_alu_q);
    end
    tick();
    i_br = 16'h0002;
    tick();
    i_br = 16'hDEAD;
    checks++;
    if (o_acc !== 16'h0002 || o_acch !== 16'h0000 || o_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_first_result got acc=%h acch=%h ready=%b exp 0002 0000 1", o_acc, o_acch, o_ready);
    end
    $display("ADD back-to-back -> acc=%h acch=%h", o_acc, o_acch);
    i_start = 1'b1; i_op = OP_SUB; i_mbr = 16'h0001;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_alu_en !== 1'b1 || o_alu_op !== OP_SUB || o_acc_alu_p !== 16'h0002) begin
      errors++; $display("FAIL b2b_second_accept got en=%b op=%b p=%h exp 1 001 0002", o_alu_en, o_alu_op, o_acc_alu_p);
    end
    tick();
    i_br = 16'h0001;
    tick();
    i_br = 16'hDEAD;
    checks++;
    if (o_acc !== 16'h0001 || o_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_second_result got acc=%h ready=%b exp 0001 1", o_acc, o_ready);
    end
    $display("SUB back-to-back -> acc=%h", o_acc);
  endtask

  task automatic test_ignore_busy();
    load_acc(16'h0010);
    i_start = 1'b1; i_op = OP_ADD; i_mbr = 16'h0005;
    tick();                                   // EXEC: offer an AND start
    i_op = OP_AND; i_mbr = 16'h0F0F;
    tick();                                   // WB_LO: offer an ACC load
    i_start = 1'b0;
    i_acc_wr = 1'b1; i_acc_wdata = 16'hFFFF;
    i_br = 16'h0015;
    checks++;
    if (o_alu_op !== OP_ADD || o_acc_alu_q !== 16'h0005 || o_c9 !== 1'b1) begin
      errors++; $display("FAIL busy_start_ignored got op=%b q=%h c9=%b exp 000 0005 1", o_alu_op, o_acc_alu_q, o_c9);
    end
    tick();                                   // IDLE
    i_acc_wr = 1'b0; i_br = 16'hDEAD;
    checks++;
    if (o_acc !== 16'h0015 || o_ready !== 1'b1 || o_alu_en !== 1'b0) begin
      errors++; $display("FAIL busy_result got acc=%h ready=%b en=%b exp 0015 1 0", o_acc, o_ready, o_alu_en);
    end
    i_start = 1'b1; i_op = OP_ADD; i_mbr = 16'h0001;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_alu_en !== 1'b1 || o_acc_alu_q !== 16'h0001) begin
      errors++; $display("FAIL busy_next_accept got en=%b q=%h exp 1 0001", o_alu_en, o_acc_alu_q);
    end
    tick();
    i_br = 16'h0016;
    tick();
    i_br = 16'hDEAD;
    checks++;
    if (o_acc !== 16'h0016) begin errors++; $display("FAIL busy_next_result got %h exp %h", o_acc, 16'h0016); end
    $display("busy-ignore sequence -> acc=%h", o_acc);
  endtask

  task automatic test_start_wins();
    load_acc(16'h0005);
    i_start = 1'b1; i_op = OP_SUB; i_mbr = 16'h0001;
    i_acc_wr = 1'b1; i_acc_wdata = 16'h1234;
    tick();
    i_start = 1'b0; i_acc_wr = 1'b0;
    checks++;
    if (o_acc_alu_p !== 16'h0005 || o_acc_alu_q !== 16'h0001 || o_alu_op !== OP_SUB) begin
      errors++; $display("FAIL startwins_exec got p=%h q=%h op=%b exp 0005 0001 001", o_acc_alu_p, o_acc_alu_q, o_alu_op);
    end
    tick();
    i_br = 16'h0004;
    tick();
    i_br = 16'hDEAD;
    checks++;
    if (o_acc !== 16'h0004) begin errors++; $display("FAIL startwins_result got %h exp %h", o_acc, 16'h0004); end
    $display("SUB with concurrent load -> acc=%h", o_acc);
  endtask

  task automatic test_reset_mid_op();
    load_acc(16'h0003);
    i_start = 1'b1; i_op = OP_ADD; i_mbr = 16'h0004;
    tick();
    i_start = 1'b0;
    tick();                                   // WB_LO
    i_br = 16'h0007;
    checks++;
    if (o_c9 !== 1'b1) begin errors++; $display("FAIL rstmid_in_wblo got c9=%b exp 1", o_c9); end
    #1 i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_ready, o_done, o_alu_en, o_c9, o_c10} !== 5'b10000 ||
        {o_acc, o_acch, o_acc_alu_p, o_acc_alu_q, o_alu_op} !== 67'd0) begin
      errors++; $display("FAIL rstmid_async got ctrl=%b acc=%h acch=%h p=%h q=%h op=%b exp ctrl=10000 data 0",
                         {o_ready, o_done, o_alu_en, o_c9, o_c10}, o_acc, o_acch, o_acc_alu_p, o_acc_alu_q, o_alu_op);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || o_acc !== 16'h0000) begin
      errors++; $display("FAIL rstmid_held got done=%b acc=%h exp 0 0000", o_done, o_acc);
    end
    i_rst_n = 1'b1;
    tick();
    checks++;
    if (o_acc !== 16'h0000 || o_ready !== 1'b1 || o_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_release got acc=%h ready=%b done=%b exp 0000 1 0", o_acc, o_ready, o_done);
    end
    i_br = 16'hDEAD;
    $display("reset during WB_LO -> acc=%h ready=%b", o_acc, o_ready);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mpy();
    test_back_to_back();
    test_ignore_busy();
    test_start_wins();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
